// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage state encoding and branch-target constants.
package fetch_unit_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
    localparam int TARG_W = 12;
    // Absolute targets; the LUT resizes them to the PC width.
    localparam logic [TARG_W-1:0] kTARG_LUT [16] = '{
        12'h010, 12'h155, 12'h2A0, 12'h3C7, 12'h07F, 12'hC12, 12'h3FF, 12'h000,
        12'h123, 12'h234, 12'h345, 12'h456, 12'h067, 12'h378, 12'h289, 12'h19A
    };
endpackage

// File: rtl/fetch_unit_branch_lut.sv
// branch_lut: maps Instruction[3:0] to an absolute branch target of PC width.
module branch_lut
    import fetch_unit_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic [3:0]      TargIdx,
    output logic [PC_W-1:0] Target
);
    assign Target = PC_W'(kTARG_LUT[TargIdx]);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter sequencing start, step, taken branch and halt.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             BranchEn,
    input  logic             Taken,
    input  logic             Ack,
    input  logic [3:0]       TargIdx,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCnt
);
    fetch_state_t state;
    logic [PC_W-1:0] target;
    branch_lut #(.PC_W(PC_W)) u_lut (.TargIdx(TargIdx), .Target(target));
    assign Running = (state == RUN);
    assign Done    = (state == HALT);
    // Start relaunches from any non-reset state, so it is checked first.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= IDLE;
            PC       <= '0;
            CycleCnt <= '0;
        end else if (Start) begin
            state    <= RUN;
            PC       <= StartAddr;
            CycleCnt <= '0;
        end else if (state == RUN) begin
            CycleCnt <= (&CycleCnt) ? CycleCnt : CycleCnt + CNT_W'(1);
            if (Ack)
                state <= HALT;
            else
                PC <= (BranchEn && Taken) ? target : PC + PC_W'(1);
        end
    end
endmodule
